fsub_seq: RTL and testbench

Multi-cycle floating-point subtractor computing result = op_a - op_b. It is the inverse-operation companion to the combinational fadd and uses the same operand and format conventions: mode_fp selects fp32 or fp16 (fp16 in bits [15:0]), and round_mode selects RNE or truncation. Alignment and normalisation are iterative, one bit per cycle, to save area. Operands enter and results leave through valid/ready handshakes, so the block sits between the FP register file and the writeback arbiter.

---
 rtl/fsub_seq.sv | 268 ++++++++++++++++++++++++++
 tb/tb_fsub_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fsub_seq.sv
// Iterative fp32/fp16 subtractor (a - b), RNE or truncate; optional flags port under FSUB_FLAGS_EN.
// Latency: specials 2 cycles, otherwise 4 + align shifts + norm shifts; in_ready low while busy, result held until out_ready.
module fsub_seq #(
   parameter int MAX_ALIGN   = 26,
   parameter int MAX_ALIGN16 = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        round_mode,
   input  logic        mode_fp,
   output logic        out_valid,
   input  logic        out_ready,
`ifdef FSUB_FLAGS_EN
   output logic [4:0]  flags,
`endif
   output logic [31:0] result
);

   typedef enum logic [2:0] {
      S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_DONE
   } state_t;

   state_t      r_state;
   logic [31:0] r_a, r_b, r_result;
   logic        r_rm, r_fp, r_sign, r_eff_sub, r_collapse;
   logic        r_in_ready, r_out_valid;
   logic [9:0]  r_exp, r_tgt, r_cnt;
   logic [27:0] r_ma, r_mb;

   function automatic logic [31:0] f_inf(input logic fp, input logic s);
      return fp ? {s, 8'hFF, 23'b0} : {16'b0, s, 5'h1F, 10'b0};
   endfunction

   function automatic logic [31:0] f_zero(input logic fp, input logic s);
      return fp ? {s, 31'b0} : {16'b0, s, 15'b0};
   endfunction

   // Field split of the latched operands
   logic [9:0]  w_ea, w_eb, w_emax, w_cap, w_diff;
   logic [22:0] w_fa, w_fb;
   logic        w_sa, w_sb, w_snb;
   logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
   logic        w_a_ge, w_eq, w_eff_sub;
   logic [27:0] w_ma_ext, w_mb_ext;
   logic [31:0] w_cnan;

   assign w_ea     = r_fp ? {2'b0, r_a[30:23]} : {5'b0, r_a[14:10]};
   assign w_eb     = r_fp ? {2'b0, r_b[30:23]} : {5'b0, r_b[14:10]};
   assign w_fa     = r_fp ? r_a[22:0] : {13'b0, r_a[9:0]};
   assign w_fb     = r_fp ? r_b[22:0] : {13'b0, r_b[9:0]};
   assign w_sa     = r_fp ? r_a[31] : r_a[15];
   assign w_sb     = r_fp ? r_b[31] : r_b[15];
   assign w_snb    = ~w_sb;
   assign w_emax   = r_fp ? 10'd255 : 10'd31;
   assign w_cap    = r_fp ? 10'(MAX_ALIGN) : 10'(MAX_ALIGN16);
   assign w_cnan   = r_fp ? 32'h7FC00000 : 32'h00007E00;
   assign w_a_zero = (w_ea == 10'd0);
   assign w_b_zero = (w_eb == 10'd0);
   assign w_a_inf  = (w_ea == w_emax) && (w_fa == 23'd0);
   assign w_b_inf  = (w_eb == w_emax) && (w_fb == 23'd0);
   assign w_a_nan  = (w_ea == w_emax) && (w_fa != 23'd0);
   assign w_b_nan  = (w_eb == w_emax) && (w_fb != 23'd0);
   assign w_a_ge   = {w_ea, w_fa} >= {w_eb, w_fb};
   assign w_eq     = {w_ea, w_fa} == {w_eb, w_fb};
   assign w_eff_sub = (w_sa == w_sb);
   assign w_diff   = w_a_ge ? (w_ea - w_eb) : (w_eb - w_ea);

   // fp16 mantissas are left-aligned onto the fp32 layout: hidden bit at 26, carry at 27
   assign w_ma_ext = r_fp ? {2'b01, w_fa, 3'b0} : {2'b01, w_fa[9:0], 16'b0};
   assign w_mb_ext = r_fp ? {2'b01, w_fb, 3'b0} : {2'b01, w_fb[9:0], 16'b0};

   logic        w_special, w_invalid, w_spec_zero;
   logic [31:0] w_spec_res;

   always_comb begin
      w_special   = 1'b1;
      w_invalid   = 1'b0;
      w_spec_zero = 1'b0;
      w_spec_res  = 32'd0;
      if (w_a_nan || w_b_nan) begin
         w_spec_res = w_cnan;
         w_invalid  = 1'b1;
      end else if (w_a_inf && w_b_inf) begin
         if (w_sa == w_sb) begin
            w_spec_res = w_cnan;
            w_invalid  = 1'b1;
         end else begin
            w_spec_res = f_inf(r_fp, w_sa);
         end
      end else if (w_a_inf) begin
         w_spec_res = f_inf(r_fp, w_sa);
      end else if (w_b_inf) begin
         w_spec_res = f_inf(r_fp, w_snb);
      end else if (w_a_zero && w_b_zero) begin
         w_spec_res  = f_zero(r_fp, w_sa & w_snb);
         w_spec_zero = 1'b1;
      end else if (w_b_zero) begin
         w_spec_res = r_fp ? r_a : {16'b0, r_a[15:0]};
      end else if (w_a_zero) begin
         w_spec_res = r_fp ? {~r_b[31], r_b[30:0]} : {16'b0, ~r_b[15], r_b[14:0]};
      end else if (w_eq && w_eff_sub) begin
         w_spec_res  = 32'd0;
         w_spec_zero = 1'b1;
      end else begin
         w_special = 1'b0;
      end
   end

   logic [27:0] w_mb_sh, w_sum;
   assign w_mb_sh = {1'b0, r_mb[27:2], r_mb[1] | r_mb[0]};
   assign w_sum   = r_eff_sub ? (r_ma - r_mb) : (r_ma + r_mb);

   // Rounding on the kept bits; G/R/S positions depend on the format
   logic [24:0] w_kept, w_rnd;
   logic        w_g, w_r, w_s, w_inc, w_mant_ovf, w_ovf, w_inexact;
   logic [9:0]  w_exp_r;
   logic [31:0] w_norm_res, w_max_fin, w_round_res;

   assign w_kept      = r_fp ? {1'b0, r_ma[26:3]} : {14'b0, r_ma[26:16]};
   assign w_g         = r_fp ? r_ma[2] : r_ma[15];
   assign w_r         = r_fp ? r_ma[1] : r_ma[14];
   assign w_s         = r_fp ? r_ma[0] : (|r_ma[13:0]);
   assign w_inc       = r_rm & w_g & (w_r | w_s | w_kept[0]);
   assign w_rnd       = w_kept + {24'b0, w_inc};
   assign w_mant_ovf  = r_fp ? w_rnd[24] : w_rnd[11];
   assign w_exp_r     = r_exp + {9'b0, w_mant_ovf};
   assign w_ovf       = (w_exp_r >= w_emax);
   assign w_inexact   = w_g | w_r | w_s;
   assign w_norm_res  = r_fp ? {r_sign, w_exp_r[7:0], w_rnd[22:0]}
                             : {16'b0, r_sign, w_exp_r[4:0], w_rnd[9:0]};
   assign w_max_fin   = r_fp ? {r_sign, 31'h7F7FFFFF} : {16'b0, r_sign, 15'h7BFF};
   assign w_round_res = w_ovf ? (r_rm ? f_inf(r_fp, r_sign) : w_max_fin) : w_norm_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= 32'd0;
         r_b         <= 32'd0;
         r_rm        <= 1'b0;
         r_fp        <= 1'b0;
         r_sign      <= 1'b0;
         r_eff_sub   <= 1'b0;
         r_collapse  <= 1'b0;
         r_exp       <= 10'd0;
         r_tgt       <= 10'd0;
         r_cnt       <= 10'd0;
         r_ma        <= 28'd0;
         r_mb        <= 28'd0;
         r_result    <= 32'd0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= op_a;
                  r_b        <= op_b;
                  r_rm       <= round_mode;
                  r_fp       <= mode_fp;
                  r_in_ready <= 1'b0;
                  r_state    <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               if (w_special) begin
                  r_result    <= w_spec_res;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_sign     <= w_a_ge ? w_sa : w_snb;
                  r_exp      <= w_a_ge ? w_ea : w_eb;
                  r_ma       <= w_a_ge ? w_ma_ext : w_mb_ext;
                  r_mb       <= w_a_ge ? w_mb_ext : w_ma_ext;
                  r_eff_sub  <= w_eff_sub;
                  r_tgt      <= (w_diff > w_cap) ? w_cap : w_diff;
                  r_collapse <= (w_diff > w_cap);
                  r_cnt      <= 10'd0;
                  r_state    <= (w_diff == 10'd0) ? S_ADDSUB : S_ALIGN;
               end
            end
            S_ALIGN: begin
               r_cnt <= r_cnt + 10'd1;
               if (r_cnt + 10'd1 == r_tgt) begin
                  r_mb    <= r_collapse ? {27'b0, |r_mb} : w_mb_sh;
                  r_state <= S_ADDSUB;
               end else begin
                  r_mb <= w_mb_sh;
               end
            end
            S_ADDSUB: begin
               if (w_sum == 28'd0) begin
                  r_result    <= 32'd0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (w_sum[27]) begin
                  r_ma    <= {1'b0, w_sum[27:2], w_sum[1] | w_sum[0]};
                  r_exp   <= r_exp + 10'd1;
                  r_state <= S_ROUND;
               end else begin
                  r_ma    <= w_sum;
                  r_state <= w_sum[26] ? S_ROUND : S_NORM;
               end
            end
            S_NORM: begin
               r_ma  <= {r_ma[26:0], 1'b0};
               r_exp <= r_exp - 10'd1;
               if (r_exp == 10'd1) begin
                  r_result    <= f_zero(r_fp, r_sign);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (r_ma[25]) begin
                  r_state <= S_ROUND;
               end
            end
            S_ROUND: begin
               r_result    <= w_round_res;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef FSUB_FLAGS_EN
   // {invalid, overflow, underflow, inexact, zero}
   logic [4:0] r_flags;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags <= 5'd0;
      end else begin
         case (r_state)
            S_IDLE:   if (in_valid && r_in_ready) r_flags <= 5'd0;
            S_UNPACK: if (w_special) r_flags <= {w_invalid, 3'b0, w_spec_zero};
            S_ADDSUB: if (w_sum == 28'd0) r_flags[0] <= 1'b1;
            S_NORM: begin
               if (r_exp == 10'd1) begin
                  r_flags[2] <= 1'b1;
                  r_flags[0] <= 1'b1;
               end
            end
            S_ROUND: begin
               r_flags[3] <= w_ovf;
               r_flags[1] <= w_inexact;
            end
            default: r_flags <= r_flags;
         endcase
      end
   end
   assign flags = r_flags;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;

endmodule

// File: tb/tb_fsub_seq.sv
// Directed bench for fsub_seq: hand-computed results and accept-to-valid cycle counts.
module tb_fsub_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        round_mode = 1'b0;
   logic        mode_fp = 1'b1;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
`ifdef FSUB_FLAGS_EN
   logic [4:0]  flags;
`endif
   logic [4:0]  last_flags = 5'd0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   fsub_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .round_mode (round_mode),
      .mode_fp    (mode_fp),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef FSUB_FLAGS_EN
      .flags      (flags),
`endif
      .result     (result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic rm, input logic fp);
      int guard;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      op_a = a; op_b = b; round_mode = rm; mode_fp = fp;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Returns the number of rising edges from the accept edge to the one raising out_valid.
   task automatic wait_valid(output int cyc);
      cyc = 1;
      while (!out_valid && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
`ifdef FSUB_FLAGS_EN
      last_flags = flags;
`endif
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic rm, input logic fp, input logic [31:0] expr, input int expc);
      int cyc;
      start_op(a, b, rm, fp);
      wait_valid(cyc);
      chk({tag, "_res"}, result, expr);
      chk({tag, "_cyc"}, 32'(cyc), 32'(expc));
      @(posedge clk); #1;
      chk({tag, "_drop"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      int cyc;
      int seen;
      logic [31:0] held;

      #12;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
`ifdef FSUB_FLAGS_EN
      chk("rst_flags", {27'b0, flags}, 32'd0);
`endif
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      run("sub32",   32'h40300000, 32'h3F000000, 1'b1, 1'b1, 32'h40100000, 6);
      run("xx_trn",  32'h3FC00000, 32'h3FC00000, 1'b0, 1'b1, 32'h00000000, 2);
      run("xx_rne",  32'h3FC00000, 32'h3FC00000, 1'b1, 1'b1, 32'h00000000, 2);
      run("xx_h",    32'hDEAD3E00, 32'h00003E00, 1'b1, 1'b0, 32'h00000000, 2);
      run("infinf",  32'h7F800000, 32'h7F800000, 1'b1, 1'b1, 32'h7FC00000, 2);
`ifdef FSUB_FLAGS_EN
      chk("infinf_invalid", {31'b0, last_flags[4]}, 32'd1);
`endif
      run("infninf", 32'h7F800000, 32'hFF800000, 1'b1, 1'b1, 32'h7F800000, 2);
      run("fininf",  32'h3F800000, 32'h7F800000, 1'b1, 1'b1, 32'hFF800000, 2);
      run("nan32",   32'h7F800001, 32'h3F800000, 1'b1, 1'b1, 32'h7FC00000, 2);
      run("nan16",   32'h00007C01, 32'h00003C00, 1'b0, 1'b0, 32'h00007E00, 2);
      run("rnd_rne", 32'h40900000, 32'hBE7FFFFF, 1'b1, 1'b1, 32'h40980000, 9);
`ifdef FSUB_FLAGS_EN
      chk("rnd_inexact", {31'b0, last_flags[1]}, 32'd1);
`endif
      run("rnd_trn", 32'h40900000, 32'hBE7FFFFF, 1'b0, 1'b1, 32'h4097FFFF, 9);
      run("h_sub",   32'h12344100, 32'h00003800, 1'b1, 1'b0, 32'h00004000, 6);
      run("h_norm",  32'h00004080, 32'h00003800, 1'b1, 1'b0, 32'h00003F00, 7);
      run("norm32",  32'h3F800000, 32'h3F400000, 1'b1, 1'b1, 32'h3E800000, 7);
      run("ovf_rne", 32'h7F7FFFFF, 32'hF3800000, 1'b1, 1'b1, 32'h7F800000, 27);
      run("ovf_trn", 32'h7F7FFFFF, 32'hF3800000, 1'b0, 1'b1, 32'h7F7FFFFF, 27);
      run("cap_rne", 32'h3F800000, 32'h2F800000, 1'b1, 1'b1, 32'h3F800000, 31);
      run("cap_trn", 32'h3F800000, 32'h2F800000, 1'b0, 1'b1, 32'h3F7FFFFF, 31);

      // Backpressure: result must hold and a second request must be ignored
      out_ready = 1'b0;
      start_op(32'h40300000, 32'h3F000000, 1'b1, 1'b1);
      wait_valid(cyc);
      chk("bp_res", result, 32'h40100000);
      held = result;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            op_a = 32'h3F800000; op_b = 32'h3F400000; in_valid = 1'b1;
         end
         @(posedge clk); #1;
         chk("bp_hold_vld", {31'b0, out_valid}, 32'd1);
         chk("bp_hold_res", result, held);
         chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_vld", {31'b0, out_valid}, 32'd0);
      chk("bp_release_rdy", {31'b0, in_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("bp_no_extra", 32'(seen), 32'd0);

      // Reset while the capped alignment is running
      start_op(32'h3F800000, 32'h2F800000, 1'b1, 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_result", result, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("mid_rst_no_stale", 32'(seen), 32'd0);
      run("after_rst", 32'h40300000, 32'h3F000000, 1'b1, 1'b1, 32'h40100000, 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
